// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised full-duplex UART core (data width, parity, stop bits)
module uart_core_param #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(BIT_CYC / 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                tx_state_q, tx_state_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [3:0]            tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_bit_end;

    // Line level is registered from the next state so the pin never glitches on decode.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                tx_cnt_d = '0;
                tx_idx_d = '0;
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_d = S_DATA;
                    tx_idx_d   = '0;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == DATA_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == STOP_LAST) begin
                        tx_done    = 1'b1;
                        tx_ready   = 1'b1;
                        tx_idx_d   = '0;
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Accepting in the last stop cycle lets a held tx_valid start the next frame with no gap.
        if (tx_ready && tx_valid) begin
            tx_shift_d = tx_data;
            tx_par_d   = (^tx_data) ^ PAR_ODD;
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_idx_d   = '0;
        end
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_bit_end = (tx_cnt_q == CNT_LAST);
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    state_t                rx_state_q, rx_state_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [3:0]            rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  rx_perr_acc_q, rx_perr_acc_d;
    logic                  rx_ferr_acc_q, rx_ferr_acc_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rx_fall, rx_bit_end;

    // Only a falling edge starts a frame, so a held-low break cannot retrigger.
    assign rx_fall    = rx_prev_q & ~rx_sync_q;
    assign rx_bit_end = (rx_cnt_q == CNT_LAST);

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_bit_end ? '0 : rx_cnt_q + CW'(1);
        rx_idx_d      = rx_idx_q;
        rx_shift_d    = rx_shift_q;
        rx_perr_acc_d = rx_perr_acc_q;
        rx_ferr_acc_d = rx_ferr_acc_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_perr_d     = 1'b0;
        rx_ferr_d     = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d      = '0;
                rx_idx_d      = '0;
                rx_perr_acc_d = 1'b0;
                rx_ferr_acc_d = 1'b0;
                if (rx_fall) begin
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DATA_LAST) begin
                        rx_idx_d   = '0;
                        rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_bit_end) begin
                    rx_perr_acc_d = (^rx_shift_q) ^ PAR_ODD ^ rx_sync_q;
                    rx_state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_bit_end) begin
                    rx_ferr_acc_d = rx_ferr_acc_q | ~rx_sync_q;
                    if (rx_idx_q == STOP_LAST) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_perr_d  = rx_perr_acc_q;
                        rx_ferr_d  = rx_ferr_acc_q | ~rx_sync_q;
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_cnt_q      <= '0;
            rx_idx_q      <= '0;
            rx_shift_q    <= '0;
            rx_perr_acc_q <= 1'b0;
            rx_ferr_acc_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_idx_q      <= rx_idx_d;
            rx_shift_q    <= rx_shift_d;
            rx_perr_acc_q <= rx_perr_acc_d;
            rx_ferr_acc_q <= rx_ferr_acc_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - directed bench for uart_core_param in three configurations
module tb_uart_core_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       loop_en = 1'b0;
    logic       drv_rx = 1'b1;
    logic       par_rx = 1'b1;
    logic       st2_rx = 1'b1;
    logic       def_rx;

    logic       d_tx_ready, d_tx, d_tx_done, d_rx_valid, d_perr, d_ferr;
    logic [7:0] d_rx_data;
    logic       p_tx_ready, p_tx, p_tx_done, p_rx_valid, p_perr, p_ferr;
    logic [7:0] p_rx_data;
    logic       s_tx_ready, s_tx, s_tx_done, s_rx_valid, s_perr, s_ferr;
    logic [7:0] s_rx_data;

    int tests = 0;
    int fails = 0;

    assign def_rx = loop_en ? d_tx : drv_rx;

    uart_core_param u_def (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(d_tx_ready), .tx(d_tx), .tx_done(d_tx_done), .rx(def_rx),
        .rx_data(d_rx_data), .rx_valid(d_rx_valid),
        .rx_parity_err(d_perr), .rx_frame_err(d_ferr)
    );

    uart_core_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst(rst), .tx_data(8'h00), .tx_valid(1'b0),
        .tx_ready(p_tx_ready), .tx(p_tx), .tx_done(p_tx_done), .rx(par_rx),
        .rx_data(p_rx_data), .rx_valid(p_rx_valid),
        .rx_parity_err(p_perr), .rx_frame_err(p_ferr)
    );

    uart_core_param #(.STOP_BITS(2)) u_st2 (
        .clk(clk), .rst(rst), .tx_data(8'h00), .tx_valid(1'b0),
        .tx_ready(s_tx_ready), .tx(s_tx), .tx_done(s_tx_done), .rx(st2_rx),
        .rx_data(s_rx_data), .rx_valid(s_rx_valid),
        .rx_parity_err(s_perr), .rx_frame_err(s_ferr)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int hs_cnt = 0, last_hs_cyc = 0, done_cnt = 0, last_done_cyc = 0;
    int d_cnt = 0, d_last_cyc = 0, p_cnt = 0, s_cnt = 0, leak = 0;
    logic [7:0] d_last_data = 8'h00, p_last_data = 8'h00, s_last_data = 8'h00;
    logic d_last_perr = 1'b0, d_last_ferr = 1'b0, p_last_perr = 1'b0;
    logic p_last_ferr = 1'b0, s_last_perr = 1'b0, s_last_ferr = 1'b0;
    logic [7:0] rx_hist [8];

    always @(negedge clk) begin
        if (tx_valid && d_tx_ready) begin
            hs_cnt <= hs_cnt + 1;
            last_hs_cyc <= cyc;
        end
        if (d_tx_done) begin
            done_cnt <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (d_rx_valid) begin
            d_cnt <= d_cnt + 1;
            d_last_cyc <= cyc;
            d_last_data <= d_rx_data;
            d_last_perr <= d_perr;
            d_last_ferr <= d_ferr;
            rx_hist[d_cnt % 8] <= d_rx_data;
        end
        if (p_rx_valid) begin
            p_cnt <= p_cnt + 1;
            p_last_data <= p_rx_data;
            p_last_perr <= p_perr;
            p_last_ferr <= p_ferr;
        end
        if (s_rx_valid) begin
            s_cnt <= s_cnt + 1;
            s_last_data <= s_rx_data;
            s_last_perr <= s_perr;
            s_last_ferr <= s_ferr;
        end
        if ((!d_rx_valid && (d_perr || d_ferr)) || (!p_rx_valid && (p_perr || p_ferr)) ||
            (!s_rx_valid && (s_perr || s_ferr)))
            leak <= leak + 1;
    end

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0: drv_rx = v;
            1: par_rx = v;
            default: st2_rx = v;
        endcase
    endtask

    task automatic drive_frame(input int sel, input logic [11:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            set_line(sel, bits[b]);
            repeat (104) @(posedge clk);
            #1;
        end
        set_line(sel, 1'b1);
    endtask

    task automatic tx_send(input logic [7:0] v);
        tx_data = v;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit timed_out);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        timed_out = (done_cnt < target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (d_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %0b expected 1", d_tx); end
        tests++; if (d_tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %0b expected 1", d_tx_ready); end
        tests++; if (d_tx_done !== 1'b0) begin fails++; $display("FAIL reset_tx_done: got %0b expected 0", d_tx_done); end
        tests++; if (d_rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %02h expected 00", d_rx_data); end
        tests++; if (d_rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %0b expected 0", d_rx_valid); end
        tests++; if ({d_perr, d_ferr, p_perr, s_ferr} !== 4'b0000) begin
            fails++; $display("FAIL reset_err_flags: got %04b expected 0000", {d_perr, d_ferr, p_perr, s_ferr});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({d_tx, d_tx_ready, d_rx_valid} !== 3'b110) begin
            fails++; $display("FAIL idle_after_reset: got %03b expected 110", {d_tx, d_tx_ready, d_rx_valid});
        end
    endtask

    task automatic test_loopback_a5();
        int seg_err [10];
        int ready_err = 0, done_err = 0, s, b_rx, lat;
        logic [7:0] exp_bits;
        logic e;
        exp_bits = 8'hA5;
        foreach (seg_err[i]) seg_err[i] = 0;
        loop_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b_rx = d_cnt;
        tx_send(8'hA5);
        tx_data = 8'h3E;
        for (int j = 1; j <= 1040; j++) begin
            s = (j <= 104) ? 0 : (j <= 936) ? 1 + (j - 105) / 104 : 9;
            e = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : exp_bits[s-1];
            if (d_tx !== e) seg_err[s]++;
            if (d_tx_ready !== (j == 1040)) ready_err++;
            if (d_tx_done !== (j == 1040)) done_err++;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (seg_err[k] !== 0) begin fails++; $display("FAIL tx_line_bit%0d: %0d wrong cycles, expected 0", k, seg_err[k]); end
        end
        tests++; if (ready_err !== 0) begin fails++; $display("FAIL tx_ready_profile: %0d wrong cycles, expected 0", ready_err); end
        tests++; if (done_err !== 0) begin fails++; $display("FAIL tx_done_profile: %0d wrong cycles, expected 0", done_err); end
        tests++; if (last_done_cyc - last_hs_cyc !== 1040) begin
            fails++; $display("FAIL tx_done_latency: got %0d expected 1040", last_done_cyc - last_hs_cyc);
        end
        tests++; if (d_cnt - b_rx !== 1) begin fails++; $display("FAIL loop_rx_count: got %0d expected 1", d_cnt - b_rx); end
        tests++; if (d_last_data !== 8'hA5) begin fails++; $display("FAIL loop_rx_data: got %02h expected a5", d_last_data); end
        tests++; if ({d_last_perr, d_last_ferr} !== 2'b00) begin
            fails++; $display("FAIL loop_rx_err: got %02b expected 00", {d_last_perr, d_last_ferr});
        end
        lat = d_last_cyc - last_hs_cyc;
        tests++; if (lat < 988 || lat > 994) begin fails++; $display("FAIL loop_rx_latency: got %0d expected 988..994", lat); end
    endtask

    task automatic test_back_to_back();
        int b_hs, b_done, b_rx, n;
        bit to;
        b_hs = hs_cnt; b_done = done_cnt; b_rx = d_cnt;
        loop_en = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        n = 0;
        while (hs_cnt == b_hs && n < 50) begin @(posedge clk); #1; n++; end
        tx_data = 8'hFF;
        n = 0;
        while (done_cnt == b_done && n < 1200) begin @(posedge clk); #1; n++; end
        tests++; if (d_tx !== 1'b0) begin fails++; $display("FAIL b2b_no_gap_start: got %0b expected 0", d_tx); end
        tests++; if (last_hs_cyc !== last_done_cyc) begin
            fails++; $display("FAIL b2b_handshake_at_done: got cycle %0d expected %0d", last_hs_cyc, last_done_cyc);
        end
        tx_valid = 1'b0;
        wait_done(b_done + 2, to);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (to) begin fails++; $display("FAIL b2b_timeout: got %0d tx_done expected 2", done_cnt - b_done); end
        tests++; if (hs_cnt - b_hs !== 2) begin fails++; $display("FAIL b2b_handshakes: got %0d expected 2", hs_cnt - b_hs); end
        tests++; if (done_cnt - b_done !== 2) begin fails++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt - b_done); end
        tests++; if (d_cnt - b_rx !== 2) begin fails++; $display("FAIL b2b_rx_count: got %0d expected 2", d_cnt - b_rx); end
        tests++; if (rx_hist[b_rx % 8] !== 8'h00) begin fails++; $display("FAIL b2b_rx_first: got %02h expected 00", rx_hist[b_rx % 8]); end
        tests++; if (rx_hist[(b_rx + 1) % 8] !== 8'hFF) begin
            fails++; $display("FAIL b2b_rx_second: got %02h expected ff", rx_hist[(b_rx + 1) % 8]);
        end
    endtask

    task automatic test_parity();
        int b;
        b = p_cnt;
        drive_frame(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (p_cnt - b !== 1) begin fails++; $display("FAIL par_bad_count: got %0d expected 1", p_cnt - b); end
        tests++; if (p_last_data !== 8'h03) begin fails++; $display("FAIL par_bad_data: got %02h expected 03", p_last_data); end
        tests++; if (p_last_perr !== 1'b1) begin fails++; $display("FAIL par_bad_perr: got %0b expected 1", p_last_perr); end
        tests++; if (p_last_ferr !== 1'b0) begin fails++; $display("FAIL par_bad_ferr: got %0b expected 0", p_last_ferr); end
        drive_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (p_cnt - b !== 2) begin fails++; $display("FAIL par_good_count: got %0d expected 2", p_cnt - b); end
        tests++; if (p_last_data !== 8'h07) begin fails++; $display("FAIL par_good_data: got %02h expected 07", p_last_data); end
        tests++; if ({p_last_perr, p_last_ferr} !== 2'b00) begin
            fails++; $display("FAIL par_good_err: got %02b expected 00", {p_last_perr, p_last_ferr});
        end
    endtask

    task automatic test_stop2();
        int b;
        b = s_cnt;
        drive_frame(2, {1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (s_cnt - b !== 1) begin fails++; $display("FAIL stop2_count: got %0d expected 1", s_cnt - b); end
        tests++; if (s_last_data !== 8'h5A) begin fails++; $display("FAIL stop2_data: got %02h expected 5a", s_last_data); end
        tests++; if (s_last_ferr !== 1'b1) begin fails++; $display("FAIL stop2_ferr: got %0b expected 1", s_last_ferr); end
        tests++; if (s_last_perr !== 1'b0) begin fails++; $display("FAIL stop2_perr: got %0b expected 0", s_last_perr); end
    endtask

    task automatic test_glitch();
        int b;
        loop_en = 1'b0;
        drv_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        b = d_cnt;
        drv_rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        drv_rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests++; if (d_cnt !== b) begin fails++; $display("FAIL glitch_no_valid: got %0d frames expected 0", d_cnt - b); end
        drive_frame(0, {1'b1, 8'h3C, 1'b0}, 10);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (d_cnt - b !== 1) begin fails++; $display("FAIL glitch_next_count: got %0d expected 1", d_cnt - b); end
        tests++; if (d_last_data !== 8'h3C) begin fails++; $display("FAIL glitch_next_data: got %02h expected 3c", d_last_data); end
        tests++; if ({d_last_perr, d_last_ferr} !== 2'b00) begin
            fails++; $display("FAIL glitch_next_err: got %02b expected 00", {d_last_perr, d_last_ferr});
        end
    endtask

    task automatic test_reset_mid_frame();
        int b_done, b_rx;
        bit to;
        loop_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tx_send(8'h55);
        repeat (400) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (d_tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %0b expected 1", d_tx); end
        tests++; if (d_tx_ready !== 1'b1) begin fails++; $display("FAIL rstmid_tx_ready: got %0b expected 1", d_tx_ready); end
        b_done = done_cnt; b_rx = d_cnt;
        repeat (1200) @(posedge clk);
        #1;
        tests++; if (done_cnt !== b_done) begin fails++; $display("FAIL rstmid_stray_done: got %0d expected 0", done_cnt - b_done); end
        tests++; if (d_cnt !== b_rx) begin fails++; $display("FAIL rstmid_stray_rx: got %0d expected 0", d_cnt - b_rx); end
        tx_send(8'h81);
        wait_done(b_done + 1, to);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (to) begin fails++; $display("FAIL rstmid_timeout: got %0d tx_done expected 1", done_cnt - b_done); end
        tests++; if (d_cnt - b_rx !== 1) begin fails++; $display("FAIL rstmid_rx_count: got %0d expected 1", d_cnt - b_rx); end
        tests++; if (d_last_data !== 8'h81) begin fails++; $display("FAIL rstmid_rx_data: got %02h expected 81", d_last_data); end
        tests++; if ({d_last_perr, d_last_ferr} !== 2'b00) begin
            fails++; $display("FAIL rstmid_rx_err: got %02b expected 00", {d_last_perr, d_last_ferr});
        end
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_glitch();
        test_reset_mid_frame();
        tests++; if (leak !== 0) begin fails++; $display("FAIL err_flag_outside_valid: got %0d cycles expected 0", leak); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core and the next generation of the team's fixed 8N1 uart_top.
- Runs entirely in the `clk` domain. No derived clocks; bit timing comes from per-direction clock-enable counters.
- Configurable data width, optional parity (odd or even) and 1 or 2 stop bits.
- TX uses a valid/ready handshake. RX samples at mid-bit and reports parity and framing errors.
- Sits between the system bus FIFOs and the pins.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate. BIT_CYC = CLK_FREQ/BAUD_RATE (integer division); must be >= 4.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY_EN, 0: 1 = append/check a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tx_data  in  DATA_BITS  payload to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX idle, can accept a word.
- tx  out  1  serial output; idle high.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.
- rx  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_parity_err  out  1  qualifies rx_valid: parity mismatch.
- rx_frame_err  out  1  qualifies rx_valid: a stop bit was sampled low.

Behaviour:
- Reset: the only clock is `clk`; reset is synchronous and active-high, sampled on the `clk` rising edge.
  - tx=1, tx_ready=1, tx_done=0, rx_data=0, rx_valid=0, both error outputs 0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame immediately; tx is high on the next cycle.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1. When tx_valid && tx_ready, latch tx_data, drop tx_ready and enter START on the next cycle.
  - Each state holds its line level for exactly BIT_CYC clk cycles, timed by a counter that restarts at each bit.
  - Line levels: START drives 0. DATA drives bits LSB first, DATA_BITS bits. PARITY is entered only if PARITY_EN; it drives XOR(data)^PARITY_ODD. STOP drives 1 for STOP_BITS*BIT_CYC cycles.
  - tx_done pulses in the last cycle of STOP, and tx_ready rises in the same cycle.
  - Back-to-back: if tx_valid is held high, the next START begins on the cycle after tx_done, with no extra idle gap.
  - tx_valid while tx_ready=0 is ignored; the payload is not latched.
  - tx_data changing mid-frame does not affect the frame in flight.
- RX synchroniser: 2-flop synchroniser on rx; all RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1->0 transition on the synchronised rx enters START with the counter at 0.
  - START: at count BIT_CYC/2 re-sample rx. If high, this is a false start: return to IDLE with no rx_valid. If low, proceed.
  - Each following bit is sampled BIT_CYC cycles after the previous sample point, i.e. at mid-bit. Data is shifted in LSB first.
  - PARITY: present only if PARITY_EN. Error if XOR(data)^PARITY_ODD != sampled bit.
  - STOP: STOP_BITS samples. Any low sample sets the frame error.
  - After the final stop sample, in the same cycle: update rx_data, pulse rx_valid for one cycle, and drive both error flags. The FSM returns to IDLE immediately so the next start edge is accepted.
  - Error flags are valid only while rx_valid=1 and are 0 otherwise.
  - A frame with errors still updates rx_data.
  - A break (rx held low) yields one frame with rx_data=0 and rx_frame_err=1. No new start is detected until rx returns high.
- TX and RX are fully independent; simultaneous activity is required to work.
- Latency: rx_valid rises at most 2 (sync) + ceil(BIT_CYC/2) cycles after the start edge plus the frame length; the bench allows ±3 cycles.

Test Plan:
- Defaults (BIT_CYC=104), loop tx->rx, send 0xA5 -> tx low for 104 cycles, then bits 1,0,1,0,0,1,0,1; tx_done 1040 cycles after handshake; rx_valid with rx_data=0xA5, no errors; tx_ready low throughout the frame.
- tx_valid held high with 0x00 then 0xFF -> two frames with zero idle gap; exactly one handshake per frame; exactly 2 tx_done pulses.
- PARITY_EN=1, PARITY_ODD=0, drive rx frame 0x03 with parity bit 1 -> rx_valid=1, rx_data=0x03, rx_parity_err=1, rx_frame_err=0.
- STOP_BITS=2, drive 0x5A with second stop bit low -> rx_frame_err=1, rx_data=0x5A.
- 30-cycle low glitch on rx (less than BIT_CYC/2) -> no rx_valid; a valid frame 0x3C immediately after is received correctly.
- Assert rst for 1 cycle mid-DATA of a TX frame and an RX frame -> next cycle tx=1, tx_ready=1, no tx_done or rx_valid from the aborted frames; the following 0x81 transfer succeeds.
